// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output stream in, natural bin order out.
// Latency: last sample of a frame accepted at edge E -> bin 0 registered at edge E+1.
// No backpressure: input taken whenever in_valid; each frame leaves as N contiguous valid cycles.
module fft_bitrev_reorder #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_i,
  output logic             out_valid,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_i,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last
);

  typedef enum logic {S_IDLE, S_READ} state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

  // Both banks live in one array; the top address bit selects the bank.
  logic [2*DW-1:0]  r_mem [2*N];

  logic [LOG2N-1:0] r_wcnt;
  logic             r_wsel;
  state_t           r_state;
  logic [LOG2N-1:0] r_rcnt;
  logic             r_rsel;

  logic             r_out_valid;
  logic [DW-1:0]    r_out_r;
  logic [DW-1:0]    r_out_i;
  logic [LOG2N-1:0] r_out_idx;
  logic             r_out_last;

  logic             w_launch;
  logic [LOG2N-1:0] w_waddr;
  logic [2*DW-1:0]  w_rdat;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] rev;
    rev = '0;
    for (int b = 0; b < LOG2N; b++) begin
      rev[b] = k[LOG2N-1-b];
    end
    return rev;
  endfunction

  // Accepting the final sample of a frame hands the filled bank to the reader.
  assign w_launch = in_valid && (r_wcnt == LAST_IDX);
  assign w_waddr  = bitrev(r_wcnt);
  assign w_rdat   = r_mem[{r_rsel, r_rcnt}];

  // Scatter each arriving sample to its natural-order slot in the write bank.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[{r_wsel, w_waddr}] <= {in_r, in_i};
    end
  end

  // Write counter and bank select; the counter wraps naturally at N.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
      r_wsel <= 1'b0;
    end else if (in_valid) begin
      r_wcnt <= r_wcnt + ONE;
      if (w_launch) begin
        r_wsel <= ~r_wsel;
      end
    end
  end

  // Reader FSM: streams a full bank in index order, chaining straight into the next bank when ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rcnt      <= '0;
      r_rsel      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          if (w_launch) begin
            r_state <= S_READ;
            r_rcnt  <= '0;
            r_rsel  <= r_wsel;
          end
        end
        S_READ: begin
          r_out_valid <= 1'b1;
          r_out_r     <= w_rdat[2*DW-1:DW];
          r_out_i     <= w_rdat[DW-1:0];
          r_out_idx   <= r_rcnt;
          r_out_last  <= (r_rcnt == LAST_IDX);
          r_rcnt      <= r_rcnt + ONE;
          if (r_rcnt == LAST_IDX) begin
            if (w_launch) begin
              r_rsel <= r_wsel;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder: scoreboard-checked random and directed frames at N=32, plus an N=8 instance.
module tb_fft_bitrev_reorder;

  localparam int N  = 32;
  localparam int LG = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_r, in_i;
  logic          out_valid;
  logic [DW-1:0] out_r, out_i;
  logic [LG-1:0] out_idx;
  logic          out_last;

  logic          in_valid8;
  logic [DW-1:0] in_r8, in_i8;
  logic          out_valid8;
  logic [DW-1:0] out_r8, out_i8;
  logic [2:0]    out_idx8;
  logic          out_last8;

  fft_bitrev_reorder #(.N(N), .LOG2N(LG), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last)
  );

  fft_bitrev_reorder #(.N(8), .LOG2N(3), .DW(DW)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_r(in_r8), .in_i(in_i8),
    .out_valid(out_valid8), .out_r(out_r8), .out_i(out_i8), .out_idx(out_idx8), .out_last(out_last8)
  );

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a frame is a list of arrival-ordered samples; sample k belongs to bin bitrev(k).
  typedef struct {
    int            cyc;
    logic [LG-1:0] idx;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          last;
  } exp_t;

  logic [2*DW-1:0] frm[$];
  exp_t            q[$];
  int              rst_chk = -1;

  function automatic int brev(input int k, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  // Sample accepted at edge e; a completed frame schedules bins 0..N-1 on edges e+1..e+N.
  task automatic accept(input logic [DW-1:0] r, input logic [DW-1:0] i, input int e);
    logic [2*DW-1:0] nat [N];
    exp_t x;
    frm.push_back({r, i});
    if (frm.size() == N) begin
      for (int k = 0; k < N; k++) nat[brev(k, LG)] = frm[k];
      for (int j = 0; j < N; j++) begin
        x.cyc  = e + 1 + j;
        x.idx  = LG'(j);
        x.r    = nat[j][2*DW-1:DW];
        x.i    = nat[j][DW-1:0];
        x.last = (j == N - 1);
        q.push_back(x);
      end
      frm.delete();
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] r, input logic [DW-1:0] i);
    @(negedge clk);
    in_valid = v;
    in_r     = r;
    in_i     = i;
    if (v) accept(r, i, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) drive(1'b0, '0, '0);
  endtask

  // One-edge reset: drops the partial frame and every output scheduled at or after the reset edge.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    rst_chk  = cyc + 1;
    frm.delete();
    while (q.size() > 0 && q[$].cyc >= cyc + 1) void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares every cycle against the scoreboard, independent of the stimulus thread.
  bit   mon_en = 1'b0;
  bit   ev;
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      ev = (q.size() > 0) && (q[0].cyc == cyc);
      check("out_valid", 64'(out_valid), 64'(ev));
      if (ev) begin
        e = q.pop_front();
        check("out_idx_r_i_last", {out_idx, out_r, out_i, out_last}, {e.idx, e.r, e.i, e.last});
      end else begin
        check("out_last_idle", 64'(out_last), 64'(0));
      end
      if (cyc == rst_chk) begin
        check("reset_clears_out", {out_valid, out_r, out_i, out_idx, out_last}, 64'(0));
      end
    end
  end

  int              e8, first8, n8, last_idx8;
  logic [2*DW-1:0] got8 [8];

  function automatic logic [2*DW-1:0] exp8(input int k);
    if (k == 1) return {16'h8000, 16'h7FFF};
    return {16'(k * 3), 16'(k + 40)};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0;
    in_valid8 = 1'b0; in_r8 = '0; in_i8 = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {out_valid, out_r, out_i, out_idx, out_last}, 64'(0));
    check("reset_state8", 64'(out_valid8), 64'(0));
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single continuous frame: in_r=k, in_i=-k.
    for (int k = 0; k < N; k++) drive(1'b1, 16'(k), 16'(-k));
    idle(40);

    // Two back-to-back frames, no input gap between them.
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N; k++) drive(1'b1, 16'(f * 100 + k), 16'($urandom));
    idle(40);

    // Gapped frame: valid toggles every cycle.
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 16'(k), 16'(-k));
      drive(1'b0, 16'hDEAD, 16'hBEEF);
    end
    idle(40);

    // Reset after 10 inputs of frame A, then a full frame B.
    for (int k = 0; k < 10; k++) drive(1'b1, 16'(500 + k), 16'(k));
    do_reset();
    for (int k = 0; k < N; k++) drive(1'b1, 16'(200 + k), 16'($urandom));
    idle(40);

    // Reset landing on the edge that would register bin 12.
    for (int k = 0; k < N; k++) drive(1'b1, 16'(300 + k), 16'($urandom));
    idle(12);
    do_reset();
    for (int k = 0; k < N; k++) drive(1'b1, 16'(400 + k), 16'(-k));
    idle(40);

    // Extremes at k=1 (lands on bin 16).
    for (int k = 0; k < N; k++)
      drive(1'b1, (k == 1) ? 16'h8000 : 16'($urandom), (k == 1) ? 16'h7FFF : 16'($urandom));
    idle(40);

    // Random data with random gaps.
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++) begin
        while ($urandom_range(0, 2) == 0) drive(1'b0, 16'($urandom), 16'($urandom));
        drive(1'b1, 16'($urandom), 16'($urandom));
      end
    idle(60);
    check("scoreboard_drained", 64'(q.size()), 64'(0));

    // N=8 instance: extremes at k=1 must appear at bin 4.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid8 = 1'b1;
      {in_r8, in_i8} = exp8(k);
      e8 = cyc + 1;
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    n8 = 0; first8 = -1; last_idx8 = -1;
    for (int j = 0; j < 8; j++) got8[j] = '0;
    for (int t = 0; t < 14; t++) begin
      if (out_valid8) begin
        got8[out_idx8] = {out_r8, out_i8};
        if (n8 == 0) first8 = cyc;
        if (out_last8) last_idx8 = int'(out_idx8);
        n8++;
      end
      @(negedge clk);
    end
    check("n8_valid_count", 64'(n8), 64'(8));
    check("n8_latency", 64'(first8), 64'(e8 + 1));
    check("n8_last_idx", 64'(last_idx8), 64'(7));
    check("n8_extreme_bin4", 64'(got8[4]), {32'h0, 16'h8000, 16'h7FFF});
    for (int j = 0; j < 8; j++) check("n8_bin", 64'(got8[j]), 64'(exp8(brev(j, 3))));

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
